// File: rtl/core_mem_arbiter_pkg.sv
// Shared constants and state encoding for the core memory arbiter.
package core_mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W       = 64;
    localparam int unsigned DEF_DATA_W       = 64;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

    // Owner of the shared memory port; the registered state is the owner.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/core_mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto one shared memory port.
// Data side is preferred in IDLE unless the instruction side has been
// passed over STARVE_LIMIT times in a row.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W   = DEF_ADDR_W,
    parameter int unsigned MEM_DATA_W   = DEF_DATA_W,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                    g_clk,
    input  logic                    g_reset,

    input  logic                    imem_req,
    input  logic [MEM_ADDR_W-1:0]   imem_addr,
    input  logic                    imem_wen,
    input  logic [MEM_DATA_W/8-1:0] imem_strb,
    input  logic [MEM_DATA_W-1:0]   imem_wdata,
    output logic                    imem_gnt,
    output logic                    imem_err,
    output logic [MEM_DATA_W-1:0]   imem_rdata,

    input  logic                    dmem_req,
    input  logic [MEM_ADDR_W-1:0]   dmem_addr,
    input  logic                    dmem_wen,
    input  logic [MEM_DATA_W/8-1:0] dmem_strb,
    input  logic [MEM_DATA_W-1:0]   dmem_wdata,
    output logic                    dmem_gnt,
    output logic                    dmem_err,
    output logic [MEM_DATA_W-1:0]   dmem_rdata,

    output logic                    mem_req,
    output logic [MEM_ADDR_W-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [MEM_DATA_W/8-1:0] mem_strb,
    output logic [MEM_DATA_W-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_err,
    input  logic [MEM_DATA_W-1:0]   mem_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // State and starvation counter registers.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Arbitration, completion hand-off and starvation bookkeeping.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        case (state)
            ST_IDLE: begin
                if (imem_req && dmem_req) begin
                    state_nxt = starved ? ST_BUSY_I : ST_BUSY_D;
                end else if (imem_req) begin
                    state_nxt = ST_BUSY_I;
                end else if (dmem_req) begin
                    state_nxt = ST_BUSY_D;
                end
            end
            ST_BUSY_I: begin
                if (mem_gnt) begin
                    starve_cnt_nxt = '0;
                    state_nxt      = dmem_req ? ST_BUSY_D : ST_IDLE;
                end
            end
            ST_BUSY_D: begin
                if (mem_gnt) begin
                    if (imem_req && !starved) begin
                        starve_cnt_nxt = starve_cnt + CNT_W'(1);
                    end
                    state_nxt = imem_req ? ST_BUSY_I : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Route the owner's request to memory and memory's response to the owner.
    always_comb begin
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_wen    = 1'b0;
        mem_strb   = '0;
        mem_wdata  = '0;
        imem_gnt   = 1'b0;
        imem_err   = 1'b0;
        imem_rdata = '0;
        dmem_gnt   = 1'b0;
        dmem_err   = 1'b0;
        dmem_rdata = '0;
        case (state)
            ST_BUSY_I: begin
                mem_req    = 1'b1;
                mem_addr   = imem_addr;
                mem_wen    = imem_wen;
                mem_strb   = imem_strb;
                mem_wdata  = imem_wdata;
                imem_gnt   = mem_gnt;
                imem_err   = mem_err;
                imem_rdata = mem_rdata;
            end
            ST_BUSY_D: begin
                mem_req    = 1'b1;
                mem_addr   = dmem_addr;
                mem_wen    = dmem_wen;
                mem_strb   = dmem_strb;
                mem_wdata  = dmem_wdata;
                dmem_gnt   = mem_gnt;
                dmem_err   = mem_err;
                dmem_rdata = mem_rdata;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_core_mem_arbiter;

    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 64;
    localparam int unsigned SW  = DW / 8;
    localparam int          LIM = 4;

    logic          g_clk;
    logic          g_reset;
    logic          imem_req, imem_wen, imem_gnt, imem_err;
    logic [AW-1:0] imem_addr;
    logic [SW-1:0] imem_strb;
    logic [DW-1:0] imem_wdata, imem_rdata;
    logic          dmem_req, dmem_wen, dmem_gnt, dmem_err;
    logic [AW-1:0] dmem_addr;
    logic [SW-1:0] dmem_strb;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic          mem_req, mem_wen, mem_gnt, mem_err;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_strb;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    core_mem_arbiter #(
        .MEM_ADDR_W   (AW),
        .MEM_DATA_W   (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_wen   (imem_wen),
        .imem_strb  (imem_strb),
        .imem_wdata (imem_wdata),
        .imem_gnt   (imem_gnt),
        .imem_err   (imem_err),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_addr  (dmem_addr),
        .dmem_wen   (dmem_wen),
        .dmem_strb  (dmem_strb),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_err   (dmem_err),
        .dmem_rdata (dmem_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_strb   (mem_strb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_err    (mem_err),
        .mem_rdata  (mem_rdata)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // Requesters must hold req until their grant.
    a_imem_hold: assert property (@(posedge g_clk) disable iff (g_reset)
        (imem_req && !imem_gnt) |=> imem_req);
    a_dmem_hold: assert property (@(posedge g_clk) disable iff (g_reset)
        (dmem_req && !dmem_gnt) |=> dmem_req);

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_req = 0; imem_addr = '0; imem_wen = 0; imem_strb = '0; imem_wdata = '0;
        dmem_req = 0; dmem_addr = '0; dmem_wen = 0; dmem_strb = '0; dmem_wdata = '0;
        mem_gnt = 0; mem_err = 0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        g_reset = 1;
        imem_req = 1; dmem_req = 1; imem_addr = 64'hAAAA; dmem_addr = 64'hBBBB;
        dmem_wen = 1; dmem_strb = 8'hFF; dmem_wdata = '1;
        mem_gnt = 1; mem_err = 1; mem_rdata = '1;
        @(negedge g_clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        n_cmp++; if ({mem_addr, mem_wen, mem_strb, mem_wdata} !== '0) begin n_fail++; $display("FAIL reset_mem_bus got %h/%b/%h/%h want 0", mem_addr, mem_wen, mem_strb, mem_wdata); end
        n_cmp++; if ({imem_gnt, imem_err, imem_rdata} !== '0) begin n_fail++; $display("FAIL reset_imem_resp got %b/%b/%h want 0", imem_gnt, imem_err, imem_rdata); end
        n_cmp++; if ({dmem_gnt, dmem_err, dmem_rdata} !== '0) begin n_fail++; $display("FAIL reset_dmem_resp got %b/%b/%h want 0", dmem_gnt, dmem_err, dmem_rdata); end
        clear_inputs();
        @(posedge g_clk);
        @(posedge g_clk);
        #1 g_reset = 0;
    endtask

    task automatic test_imem_read();
        step();
        imem_req = 1; imem_addr = 64'h1000; imem_wen = 0;
        @(negedge g_clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL iread_decision_cycle got mem_req %b want 0", mem_req); end
        step();
        @(negedge g_clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL iread_mem_req got %b want 1", mem_req); end
        n_cmp++; if (mem_addr !== 64'h1000) begin n_fail++; $display("FAIL iread_addr got %h want 1000", mem_addr); end
        step();
        step();
        mem_gnt = 1; mem_rdata = 64'hDEAD;
        @(negedge g_clk);
        n_cmp++; if (imem_gnt !== 1'b1 || imem_rdata !== 64'hDEAD) begin n_fail++; $display("FAIL iread_resp got gnt %b rdata %h want 1/dead", imem_gnt, imem_rdata); end
        n_cmp++; if (dmem_gnt !== 1'b0 || dmem_rdata !== '0) begin n_fail++; $display("FAIL iread_dmem_quiet got gnt %b rdata %h want 0/0", dmem_gnt, dmem_rdata); end
        step();
        imem_req = 0; mem_gnt = 0; mem_rdata = '0;
        @(negedge g_clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL iread_back_to_idle got mem_req %b want 0", mem_req); end
    endtask

    task automatic test_back_to_back();
        step();
        imem_req = 1; imem_addr = 64'h2000;
        dmem_req = 1; dmem_addr = 64'h3000;
        step();
        @(negedge g_clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h3000) begin n_fail++; $display("FAIL b2b_dmem_first got req %b addr %h want 1/3000", mem_req, mem_addr); end
        mem_gnt = 1; mem_rdata = 64'h55;
        #1;
        n_cmp++; if (dmem_gnt !== 1'b1 || imem_gnt !== 1'b0) begin n_fail++; $display("FAIL b2b_dmem_gnt got d %b i %b want 1/0", dmem_gnt, imem_gnt); end
        @(posedge g_clk);
        #1 dmem_req = 0; mem_gnt = 0;
        @(negedge g_clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h2000) begin n_fail++; $display("FAIL b2b_no_bubble got req %b addr %h want 1/2000", mem_req, mem_addr); end
        mem_gnt = 1;
        @(posedge g_clk);
        #1 imem_req = 0; mem_gnt = 0;
        @(negedge g_clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got mem_req %b want 0", mem_req); end
    endtask

    // Both sides keep re-requesting; ownership alternates, dmem first.
    task automatic test_alternation();
        logic [AW-1:0] ia, da, exp;
        step();
        ia = 64'h100; da = 64'h200;
        imem_req = 1; imem_addr = ia; dmem_req = 1; dmem_addr = da;
        @(negedge g_clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL alt_decision got mem_req %b want 0", mem_req); end
        for (int r = 0; r < 6; r++) begin
            @(negedge g_clk);
            exp = (r % 2 == 0) ? da : ia;
            n_cmp++; if (mem_req !== 1'b1 || mem_addr !== exp) begin n_fail++; $display("FAIL alt_round%0d got req %b addr %h want 1/%h", r, mem_req, mem_addr, exp); end
            mem_gnt = 1;
            @(posedge g_clk);
            #1 mem_gnt = 0;
            if (r % 2 == 0) begin
                da = da + 64'h10;
                if (r < 4) dmem_addr = da; else dmem_req = 0;
            end else begin
                ia = ia + 64'h10;
                if (r < 4) imem_addr = ia; else imem_req = 0;
            end
        end
        @(negedge g_clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL alt_idle got mem_req %b want 0", mem_req); end
    endtask

    task automatic test_dmem_err();
        step();
        dmem_req = 1; dmem_addr = 64'h40; dmem_wen = 1; dmem_strb = 8'h0F;
        dmem_wdata = 64'h1122_3344_5566_7788;
        step();
        @(negedge g_clk);
        n_cmp++; if ({mem_wen, mem_strb, mem_wdata} !== {1'b1, 8'h0F, 64'h1122_3344_5566_7788}) begin n_fail++; $display("FAIL derr_write_bus got %b/%h/%h", mem_wen, mem_strb, mem_wdata); end
        mem_gnt = 1; mem_err = 1;
        #1;
        n_cmp++; if (dmem_gnt !== 1'b1 || dmem_err !== 1'b1) begin n_fail++; $display("FAIL derr_dmem got gnt %b err %b want 1/1", dmem_gnt, dmem_err); end
        n_cmp++; if (imem_err !== 1'b0 || imem_gnt !== 1'b0) begin n_fail++; $display("FAIL derr_imem_quiet got gnt %b err %b want 0/0", imem_gnt, imem_err); end
        @(posedge g_clk);
        #1 dmem_req = 0; dmem_wen = 0; dmem_strb = '0; mem_gnt = 0; mem_err = 0;
    endtask

    task automatic test_reset_mid();
        step();
        imem_req = 1; imem_addr = 64'h5000;
        step();
        @(negedge g_clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_busy got mem_req %b want 1", mem_req); end
        #2 g_reset = 1; imem_req = 0; mem_gnt = 1;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || mem_addr !== '0) begin n_fail++; $display("FAIL rmid_drop got req %b addr %h want 0/0", mem_req, mem_addr); end
        n_cmp++; if (imem_gnt !== 1'b0) begin n_fail++; $display("FAIL rmid_no_gnt got %b want 0", imem_gnt); end
        @(posedge g_clk);
        @(posedge g_clk);
        #1 g_reset = 0;
        @(negedge g_clk);
        n_cmp++; if (mem_req !== 1'b0 || imem_gnt !== 1'b0) begin n_fail++; $display("FAIL rmid_after got req %b gnt %b want 0/0", mem_req, imem_gnt); end
        mem_gnt = 0;
    endtask

    // Random traffic versus a model tracking owner and consecutive dmem wins.
    task automatic test_random(input int n);
        int owner, wins, nxt;
        bit done_i, done_d;
        logic [AW-1:0] e_addr;
        logic [1+SW+DW-1:0] e_bus;
        logic [1+1+DW-1:0] e_i, e_d;
        g_reset = 1;
        clear_inputs();
        step();
        g_reset = 0;
        owner = 0; wins = 0;
        for (int c = 0; c < n; c++) begin
            if (!imem_req && $urandom_range(2) == 0) begin
                imem_req = 1; imem_addr = {$urandom, $urandom}; imem_wen = 1'($urandom);
                imem_strb = SW'($urandom); imem_wdata = {$urandom, $urandom};
            end
            if (!dmem_req && $urandom_range(2) == 0) begin
                dmem_req = 1; dmem_addr = {$urandom, $urandom}; dmem_wen = 1'($urandom);
                dmem_strb = SW'($urandom); dmem_wdata = {$urandom, $urandom};
            end
            mem_gnt = ($urandom_range(2) != 0); mem_err = 1'($urandom);
            mem_rdata = {$urandom, $urandom};
            @(negedge g_clk);
            e_addr = (owner == 1) ? imem_addr : (owner == 2) ? dmem_addr : '0;
            e_bus  = (owner == 1) ? {imem_wen, imem_strb, imem_wdata} :
                     (owner == 2) ? {dmem_wen, dmem_strb, dmem_wdata} : '0;
            e_i = (owner == 1) ? {mem_gnt, mem_err, mem_rdata} : '0;
            e_d = (owner == 2) ? {mem_gnt, mem_err, mem_rdata} : '0;
            n_cmp++; if (mem_req !== (owner != 0)) begin n_fail++; $display("FAIL rnd_mem_req c%0d got %b want %b", c, mem_req, owner != 0); end
            n_cmp++; if (mem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr c%0d got %h want %h", c, mem_addr, e_addr); end
            n_cmp++; if ({mem_wen, mem_strb, mem_wdata} !== e_bus) begin n_fail++; $display("FAIL rnd_bus c%0d got %h want %h", c, {mem_wen, mem_strb, mem_wdata}, e_bus); end
            n_cmp++; if ({imem_gnt, imem_err, imem_rdata} !== e_i) begin n_fail++; $display("FAIL rnd_imem c%0d got %h want %h", c, {imem_gnt, imem_err, imem_rdata}, e_i); end
            n_cmp++; if ({dmem_gnt, dmem_err, dmem_rdata} !== e_d) begin n_fail++; $display("FAIL rnd_dmem c%0d got %h want %h", c, {dmem_gnt, dmem_err, dmem_rdata}, e_d); end
            done_i = (owner == 1) && mem_gnt;
            done_d = (owner == 2) && mem_gnt;
            nxt = owner;
            if (owner == 0) begin
                if (imem_req && dmem_req) nxt = (wins == LIM) ? 1 : 2;
                else if (imem_req)        nxt = 1;
                else if (dmem_req)        nxt = 2;
            end else if (done_i) begin
                wins = 0;
                nxt  = dmem_req ? 2 : 0;
            end else if (done_d) begin
                if (imem_req && wins < LIM) wins = wins + 1;
                nxt = imem_req ? 1 : 0;
            end
            owner = nxt;
            @(posedge g_clk);
            #1;
            if (done_i) imem_req = 0;
            if (done_d) dmem_req = 0;
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_imem_read();
        test_back_to_back();
        test_alternation();
        test_dmem_err();
        test_reset_mid();
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
